// File: rtl/ex_mem_stage_pkg.sv
// Shared widths, control-bit indices and the EX/MEM payload record used by the
// EX/MEM pipeline stage and its storage slot.
package ex_mem_stage_pkg;

  localparam int XLEN    = 64;
  localparam int RADDR_W = 5;
  localparam int CTRL_W  = 5;

  localparam int CTRL_REGWR   = 4;
  localparam int CTRL_MEMRD   = 3;
  localparam int CTRL_MEMWR   = 2;
  localparam int CTRL_MEM2REG = 1;
  localparam int CTRL_BRANCH  = 0;

  typedef struct packed {
    logic [XLEN-1:0]    alu_result;
    logic               z_flag;
    logic [XLEN-1:0]    rs2_data;
    logic [RADDR_W-1:0] rd;
    logic [CTRL_W-1:0]  ctrl;
  } ex_mem_payload_t;

  function automatic logic payload_br_taken(input ex_mem_payload_t p);
    return p.ctrl[CTRL_BRANCH] & p.z_flag;
  endfunction

endpackage

// File: rtl/ex_mem_slot.sv
// One EX/MEM payload entry: valid bit plus registered payload, with load and
// clear strobes. Clear wins over load so a redirect always empties the slot.
module ex_mem_slot
  import ex_mem_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clear,
  input  logic            i_load,
  input  ex_mem_payload_t i_data,
  output logic            o_valid,
  output ex_mem_payload_t o_data
);

  logic            r_valid;
  ex_mem_payload_t r_data;

  // Payload is only written on load, so it keeps its last value once drained.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with valid/ready handshake, flush and branch resolve.
// Define EX_MEM_SKID_EN for a two-entry (main + skid) buffer with registered in_ready.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_alu_result,
  input  logic               in_z_flag,
  input  logic [XLEN-1:0]    in_rs2_data,
  input  logic [RADDR_W-1:0] in_rd,
  input  logic [CTRL_W-1:0]  in_ctrl,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_alu_result,
  output logic [XLEN-1:0]    out_rs2_data,
  output logic [RADDR_W-1:0] out_rd,
  output logic [CTRL_W-1:0]  out_ctrl,
  output logic               out_br_taken
);

  ex_mem_payload_t w_in_data;
  ex_mem_payload_t w_main_data;
  ex_mem_payload_t w_main_load_data;
  logic            w_main_valid;
  logic            w_main_load;
  logic            w_main_clear;
  logic            w_in_xfer;
  logic            w_out_xfer;

  assign w_in_data = '{
    alu_result: in_alu_result,
    z_flag:     in_z_flag,
    rs2_data:   in_rs2_data,
    rd:         in_rd,
    ctrl:       in_ctrl
  };

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = w_main_valid & out_ready;

`ifdef EX_MEM_SKID_EN
  logic            w_skid_valid;
  logic            w_skid_load;
  logic            w_skid_clear;
  ex_mem_payload_t w_skid_data;

  // Skid only ever fills while main is held, so in_ready never looks at out_ready.
  assign in_ready = !w_skid_valid;

  assign w_main_load      = !flush & ((w_skid_valid & w_out_xfer) |
                                      (w_in_xfer & (!w_main_valid | out_ready)));
  assign w_main_load_data = w_skid_valid ? w_skid_data : w_in_data;
  assign w_main_clear     = flush | (w_out_xfer & !w_main_load);

  assign w_skid_load  = !flush & w_in_xfer & w_main_valid & !out_ready;
  assign w_skid_clear = flush | (w_skid_valid & w_out_xfer);

  ex_mem_slot u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_skid_clear),
    .i_load  (w_skid_load),
    .i_data  (w_in_data),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );
`else
  assign in_ready = !w_main_valid | out_ready;

  assign w_main_load      = !flush & w_in_xfer;
  assign w_main_load_data = w_in_data;
  assign w_main_clear     = flush | (w_out_xfer & !w_in_xfer);
`endif

  ex_mem_slot u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_main_clear),
    .i_load  (w_main_load),
    .i_data  (w_main_load_data),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  // Control and branch outputs are gated so a bubble can never cause a write.
  assign out_valid      = w_main_valid;
  assign out_alu_result = w_main_data.alu_result;
  assign out_rs2_data   = w_main_data.rs2_data;
  assign out_rd         = w_main_data.rd;
  assign out_ctrl       = w_main_data.ctrl & {CTRL_W{w_main_valid}};
  assign out_br_taken   = w_main_valid & payload_br_taken(w_main_data);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Randomised and directed bench for ex_mem_stage against a queue-based model
// of an in-order buffer (capacity 1, or 2 when EX_MEM_SKID_EN is defined).
module tb_ex_mem_stage;
  import ex_mem_stage_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    in_alu_result;
  logic               in_z_flag;
  logic [XLEN-1:0]    in_rs2_data;
  logic [RADDR_W-1:0] in_rd;
  logic [CTRL_W-1:0]  in_ctrl;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_alu_result;
  logic [XLEN-1:0]    out_rs2_data;
  logic [RADDR_W-1:0] out_rd;
  logic [CTRL_W-1:0]  out_ctrl;
  logic               out_br_taken;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_alu_result  (in_alu_result),
    .in_z_flag      (in_z_flag),
    .in_rs2_data    (in_rs2_data),
    .in_rd          (in_rd),
    .in_ctrl        (in_ctrl),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_alu_result (out_alu_result),
    .out_rs2_data   (out_rs2_data),
    .out_rd         (out_rd),
    .out_ctrl       (out_ctrl),
    .out_br_taken   (out_br_taken)
  );

`ifdef EX_MEM_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct {
    logic [63:0] alu;
    logic        z;
    logic [63:0] rs2;
    logic [4:0]  rd;
    logic [4:0]  ctrl;
  } beat_t;

  beat_t q[$];
  beat_t last_head;
  int    n_checks = 0;
  int    n_errors = 0;
  int    n_out    = 0;
  bit    accepted;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic beat_t rand_beat();
    beat_t b;
    b.alu  = {$urandom, $urandom};
    b.z    = 1'($urandom_range(0, 1));
    b.rs2  = {$urandom, $urandom};
    b.rd   = 5'($urandom_range(0, 31));
    b.ctrl = 5'($urandom_range(0, 31));
    return b;
  endfunction

  function automatic beat_t mk_beat(input logic [63:0] alu, input logic z,
                                    input logic [4:0] rd, input logic [4:0] ctrl);
    beat_t b;
    b.alu  = alu;
    b.z    = z;
    b.rs2  = ~alu;
    b.rd   = rd;
    b.ctrl = ctrl;
    return b;
  endfunction

  // Drive one cycle from the falling edge, check outputs, then advance the model.
  task automatic cycle(input bit rstn, input bit fl, input bit iv, input beat_t b, input bit ordy);
    bit    exp_rdy;
    bit    vld;
    beat_t head;
    rst_n         = rstn;
    flush         = fl;
    in_valid      = iv;
    in_alu_result = b.alu;
    in_z_flag     = b.z;
    in_rs2_data   = b.rs2;
    in_rd         = b.rd;
    in_ctrl       = b.ctrl;
    out_ready     = ordy;
    #1;
    vld     = (q.size() != 0);
    head    = vld ? q[0] : last_head;
    exp_rdy = (CAP == 2) ? (q.size() < 2) : (!vld || ordy);
    check_val("in_ready", 64'(in_ready), 64'(exp_rdy));
    check_val("out_valid", 64'(out_valid), 64'(vld));
    check_val("out_alu_result", out_alu_result, head.alu);
    check_val("out_rs2_data", out_rs2_data, head.rs2);
    check_val("out_rd", 64'(out_rd), 64'(head.rd));
    check_val("out_ctrl", 64'(out_ctrl), vld ? 64'(head.ctrl) : 64'd0);
    check_val("out_br_taken", 64'(out_br_taken), 64'(vld & head.ctrl[0] & head.z));
    @(posedge clk);
    accepted = 1'b0;
    if (!rstn) begin
      q.delete();
      last_head = '{default: 0};
    end else begin
      if (vld && ordy) begin
        $display("xfer out #%0d: alu=%h rs2=%h rd=%0d ctrl=%b br=%0b",
                 n_out, q[0].alu, q[0].rs2, q[0].rd, q[0].ctrl, q[0].ctrl[0] & q[0].z);
        n_out++;
        void'(q.pop_front());
      end
      if (iv && exp_rdy) begin
        accepted = 1'b1;
        if (!fl) q.push_back(b);
      end
      if (fl) q.delete();
      if (q.size() != 0) last_head = q[0];
    end
    @(negedge clk);
  endtask

  initial begin
    beat_t b;
    beat_t stall_beats[3];
    int    t;
    int    n0;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_alu_result = '1; in_z_flag = 1'b1; in_rs2_data = '1; in_rd = '1; in_ctrl = '1;
    last_head = '{default: 0};
    @(posedge clk);
    @(negedge clk);

    // Reset held with a valid input pending
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1, rand_beat(), 1'b1);

    // Pass-through, then four back-to-back beats
    cycle(1'b1, 1'b0, 1'b1, mk_beat(64'h8, 1'b0, 5'd5, 5'b10000), 1'b1);
    check_val("pass_alu", out_alu_result, 64'h8);
    check_val("pass_rd", 64'(out_rd), 64'd5);
    check_val("pass_ctrl", 64'(out_ctrl), 64'b10000);
    for (int i = 0; i < 4; i++)
      cycle(1'b1, 1'b0, 1'b1, mk_beat(64'(100 + i), 1'b0, 5'(i + 1), 5'b10010), 1'b1);
    check_val("b2b_valid", 64'(out_valid), 64'd1);

    // Branch resolve: taken, not taken, bubble
    cycle(1'b1, 1'b0, 1'b1, mk_beat(64'h0, 1'b1, 5'd0, 5'b00001), 1'b1);
    check_val("br_taken_z1", 64'(out_br_taken), 64'd1);
    cycle(1'b1, 1'b0, 1'b1, mk_beat(64'h4, 1'b0, 5'd0, 5'b00001), 1'b1);
    check_val("br_taken_z0", 64'(out_br_taken), 64'd0);
    cycle(1'b1, 1'b0, 1'b0, mk_beat(64'h0, 1'b1, 5'd0, 5'b00001), 1'b1);
    cycle(1'b1, 1'b0, 1'b0, mk_beat(64'h0, 1'b1, 5'd0, 5'b00001), 1'b1);
    check_val("br_taken_bubble", 64'(out_br_taken), 64'd0);

    // Stall with beats A, B, C; release after six cycles
    stall_beats[0] = mk_beat(64'hA, 1'b0, 5'd10, 5'b10000);
    stall_beats[1] = mk_beat(64'hB, 1'b0, 5'd11, 5'b01010);
    stall_beats[2] = mk_beat(64'hC, 1'b0, 5'd12, 5'b00100);
    n0 = n_out;
    t  = 0;
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 20; w++) begin
        cycle(1'b1, 1'b0, 1'b1, stall_beats[k], t >= 6);
        t++;
        if (accepted) break;
      end
      check_val("stall_accept", 64'(accepted), 64'd1);
    end
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, rand_beat(), 1'b1);
    check_val("stall_count", 64'(n_out - n0), 64'd3);

    // Flush a held entry while a new beat is offered
    cycle(1'b1, 1'b0, 1'b1, mk_beat(64'h55, 1'b0, 5'd7, 5'b11000), 1'b0);
    cycle(1'b1, 1'b1, 1'b1, mk_beat(64'h66, 1'b0, 5'd8, 5'b10000), 1'b0);
    check_val("flush_valid", 64'(out_valid), 64'd0);
    check_val("flush_ctrl", 64'(out_ctrl), 64'd0);
    cycle(1'b1, 1'b0, 1'b1, mk_beat(64'h77, 1'b0, 5'd9, 5'b10000), 1'b1);
    check_val("post_flush_alu", out_alu_result, 64'h77);
    cycle(1'b1, 1'b0, 1'b0, rand_beat(), 1'b1);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 10000; i++) begin
      b = rand_beat();
      cycle($urandom_range(0, 1999) != 0, $urandom_range(0, 63) == 0,
            $urandom_range(0, 9) < 7, b, $urandom_range(0, 9) < 6);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
